// File: rtl/ad7760_responder.sv
// Device-side model of the AD7760 parallel control/data bus: captures two-phase host
// register writes, holds control registers 1/2, and produces drdy_n plus an incrementing sample.
module ad7760_responder #(
    parameter int          ODR_DIV   = 32,
    parameter int          DRDY_LOW  = 4,
    parameter logic [15:0] CTRL1_RST = 16'h001A,
    parameter logic [15:0] CTRL2_RST = 16'h009B
) (
    input  logic        mclk,
    input  logic        i_rest_n,
    input  logic        dev_rest_n,
    input  logic        cs_n,
    input  logic        r_n_w,
    input  logic [15:0] db_in,
    output logic [15:0] db_out,
    output logic        db_oe,
    output logic        drdy_n,
    output logic [15:0] ctrl1_q,
    output logic [15:0] ctrl2_q,
    output logic        addr_err
);

    localparam int CW = $clog2(2 * ODR_DIV) + 1;
    localparam int LW = $clog2(DRDY_LOW) + 1;

    typedef enum logic [1:0] {IDLE, WLOW, COMMIT} wstate_t;

    logic        srst;
    assign srst = ~i_rest_n | ~dev_rest_n;

    // Write-capture path
    wstate_t     state_reg;
    logic        cs_reg;
    logic        rnw_reg;
    logic [15:0] db_reg;
    logic [1:0]  low_cnt_reg;
    logic [15:0] hold_reg;
    logic [1:0]  addr_reg;
    logic        phase_val_reg;
    logic [15:0] ctrl1_reg;
    logic [15:0] ctrl2_reg;
    logic        addr_err_reg;

    always_ff @(posedge mclk) begin
        if (srst) begin
            state_reg     <= IDLE;
            cs_reg        <= 1'b1;
            rnw_reg       <= 1'b1;
            db_reg        <= 16'h0000;
            low_cnt_reg   <= 2'd0;
            hold_reg      <= 16'h0000;
            addr_reg      <= 2'd0;
            phase_val_reg <= 1'b0;
            ctrl1_reg     <= CTRL1_RST;
            ctrl2_reg     <= CTRL2_RST;
            addr_err_reg  <= 1'b0;
        end else begin
            cs_reg  <= cs_n;
            rnw_reg <= r_n_w;
            db_reg  <= db_in;
            case (state_reg)
                IDLE: begin
                    if (!cs_reg && rnw_reg) begin
                        state_reg   <= WLOW;
                        low_cnt_reg <= 2'd1;
                        hold_reg    <= db_reg;
                    end
                end
                WLOW: begin
                    // A registered cs_n high here is the rising edge of the strobe.
                    if (cs_reg) begin
                        state_reg <= (low_cnt_reg >= 2'd2) ? COMMIT : IDLE;
                    end else if (!rnw_reg) begin
                        state_reg <= IDLE;
                    end else begin
                        hold_reg <= db_reg;
                        if (low_cnt_reg != 2'd3) begin
                            low_cnt_reg <= low_cnt_reg + 2'd1;
                        end
                    end
                end
                COMMIT: begin
                    state_reg <= IDLE;
                    if (!phase_val_reg) begin
                        addr_reg      <= hold_reg[1:0];
                        phase_val_reg <= 1'b1;
                    end else begin
                        case (addr_reg)
                            2'd1:    ctrl1_reg    <= hold_reg;
                            2'd2:    ctrl2_reg    <= hold_reg;
                            default: addr_err_reg <= 1'b1;
                        endcase
                        phase_val_reg <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Conversion engine
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] p_reg;
    logic [CW-1:0] p_sel;
    logic [CW-1:0] p_cur;
    logic [LW-1:0] low_cnt_drdy_reg;
    logic [15:0]   sample_reg;
    logic [15:0]   db_out_reg;
    logic          drdy_n_reg;

    // The period is re-sampled from ctrl2 only at the start of each period.
    always_comb begin
        p_sel = ctrl2_reg[5] ? CW'(ODR_DIV) : CW'(2 * ODR_DIV);
        p_cur = (cnt_reg == '0) ? p_sel : p_reg;
    end

    always_ff @(posedge mclk) begin
        if (srst) begin
            cnt_reg          <= '0;
            p_reg            <= CW'(2 * ODR_DIV);
            low_cnt_drdy_reg <= '0;
            sample_reg       <= 16'h0000;
            db_out_reg       <= 16'h0000;
            drdy_n_reg       <= 1'b1;
        end else if (ctrl2_reg[0]) begin
            cnt_reg          <= '0;
            low_cnt_drdy_reg <= '0;
            drdy_n_reg       <= 1'b1;
        end else begin
            p_reg <= p_cur;
            if (cnt_reg == p_cur - CW'(1)) begin
                cnt_reg          <= '0;
                db_out_reg       <= sample_reg;
                sample_reg       <= sample_reg + 16'h0001;
                drdy_n_reg       <= 1'b0;
                low_cnt_drdy_reg <= LW'(DRDY_LOW - 1);
            end else begin
                cnt_reg <= cnt_reg + CW'(1);
                if (!drdy_n_reg) begin
                    if (low_cnt_drdy_reg == '0) begin
                        drdy_n_reg <= 1'b1;
                    end else begin
                        low_cnt_drdy_reg <= low_cnt_drdy_reg - LW'(1);
                    end
                end
            end
        end
    end

    assign db_out   = db_out_reg;
    assign drdy_n   = drdy_n_reg;
    assign ctrl1_q  = ctrl1_reg;
    assign ctrl2_q  = ctrl2_reg;
    assign addr_err = addr_err_reg;
    // Combinational so the bus is released in the same cycle the host lets go.
    assign db_oe    = ~cs_n & ~r_n_w & i_rest_n & dev_rest_n;

endmodule
